// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, VEC/CTRL bit
// positions and the source-ID width.
package irq_ctrl_pkg;

  localparam int unsigned IDW = 5;

  typedef enum logic [1:0] {
    A_PEND = 2'd0,
    A_MASK = 2'd1,
    A_MODE = 2'd2,
    A_CTRL = 2'd3
  } reg_addr_e;

  localparam int unsigned ISV     = 31;
  localparam int unsigned CANDV   = 30;
  localparam int unsigned GIE_RD  = 16;
  localparam int unsigned CID_LSB = 8;
  localparam int unsigned GIE_WR  = 0;
  localparam int unsigned EOI_WR  = 1;

endpackage

// File: rtl/irq_ctrl_if.sv
// Word-addressed register bus shared with the timers on the same bridge.
interface irq_ctrl_if;
  logic [1:0]  add_i;
  logic        we_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;

  modport slave  (input  add_i, we_i, dat_i, output dat_o);
  modport master (output add_i, we_i, dat_i, input  dat_o);
endinterface

// File: rtl/irq_ctrl_prio_enc.sv
// Combinational priority encoder: lowest set request index wins.
module irq_prio_enc
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 6
) (
  input  logic [N_SRC-1:0] req_i,
  output logic [IDW-1:0]   id_o,
  output logic             valid_o
);

  // Scan downward so the final assignment is the lowest active index.
  always_comb begin
    id_o    = '0;
    valid_o = 1'b0;
    for (int unsigned i = N_SRC; i > 0; i--) begin
      if (req_i[i-1]) begin
        valid_o = 1'b1;
        id_o    = IDW'(i - 1);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches/masks/prioritises device IRQs and presents a
// single registered request plus in-service ID to CP0.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] irq_i,
  input  logic             int_ack_i,
  input  logic             eoi_i,
  output logic             int_o,
  output logic [IDW-1:0]   int_id_o
);

  logic [N_SRC-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d, irq_q;
  logic             gie_q, gie_d, isv_q, isv_d, int_q, int_d;
  logic [IDW-1:0]   isv_id_q, isv_id_d;

  logic [N_SRC-1:0] pend_v, w1c, ack_clr;
  logic [IDW-1:0]   cand_id;
  logic             cand_v, ack_fire, eoi, wr_pend, wr_ctrl;
  logic [31:0]      vec;

  // Edge-mode bits live in pend_q; level-mode bits are the registered line.
  always_comb pend_v = (pend_q & mode_q) | (irq_q & ~mode_q);

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req_i   (pend_v & mask_q),
    .id_o    (cand_id),
    .valid_o (cand_v)
  );

  always_comb begin
    wr_pend  = bus.we_i && (reg_addr_e'(bus.add_i) == A_PEND);
    wr_ctrl  = bus.we_i && (reg_addr_e'(bus.add_i) == A_CTRL);
    ack_fire = int_ack_i & int_q;
    eoi      = eoi_i | (wr_ctrl & bus.dat_i[EOI_WR]);
    w1c      = wr_pend ? bus.dat_i[N_SRC-1:0] : '0;
    ack_clr  = ack_fire ? (N_SRC'(1) << cand_id) : '0;

    pend_d   = mode_q & ((irq_i & ~irq_q) | (pend_q & ~w1c & ~ack_clr));
    mask_d   = mask_q;
    mode_d   = mode_q;
    gie_d    = gie_q;
    if (bus.we_i) begin
      case (reg_addr_e'(bus.add_i))
        A_MASK:  mask_d = bus.dat_i[N_SRC-1:0];
        A_MODE:  mode_d = bus.dat_i[N_SRC-1:0];
        A_CTRL:  gie_d  = bus.dat_i[GIE_WR];
        default: ;
      endcase
    end

    int_d    = gie_q & cand_v & ~isv_q & ~int_ack_i;
    isv_d    = ack_fire ? 1'b1 : (eoi ? 1'b0 : isv_q);
    isv_id_d = ack_fire ? cand_id : isv_id_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q   <= '0;
      mask_q   <= '0;
      mode_q   <= '0;
      irq_q    <= '0;
      gie_q    <= 1'b0;
      isv_q    <= 1'b0;
      isv_id_q <= '0;
      int_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      irq_q    <= irq_i;
      gie_q    <= gie_d;
      isv_q    <= isv_d;
      isv_id_q <= isv_id_d;
      int_q    <= int_d;
    end
  end

  always_comb begin
    vec                        = '0;
    vec[ISV]                   = isv_q;
    vec[CANDV]                 = cand_v;
    vec[GIE_RD]                = gie_q;
    vec[CID_LSB +: IDW]        = cand_id;
    vec[IDW-1:0]               = isv_id_q;
    case (reg_addr_e'(bus.add_i))
      A_PEND:  bus.dat_o = 32'(pend_v);
      A_MASK:  bus.dat_o = 32'(mask_q);
      A_MODE:  bus.dat_o = 32'(mode_q);
      default: bus.dat_o = vec;
    endcase
  end

  assign int_o    = int_q;
  assign int_id_o = isv_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboarded bench for irq_ctrl: directed scenarios plus random traffic
// checked against a behavioural model of the interrupt rules.
module tb_irq_ctrl;
  localparam int N = 6;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] irq;
  logic ack, eoi, int_o;
  logic [4:0] int_id;

  always #5 clk = ~clk;

  irq_ctrl_if bus ();

  irq_ctrl #(.N_SRC(N)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus), .irq_i(irq),
    .int_ack_i(ack), .eoi_i(eoi), .int_o(int_o), .int_id_o(int_id)
  );

  typedef struct {
    logic [31:0] dat;
    logic        io;
    logic [4:0]  id;
    int          tag;
  } exp_t;

  exp_t sb[$];
  logic rd_stb = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   tagc   = 0;

  // Reference model state
  logic [N-1:0] m_pend, m_prev, m_mask, m_mode;
  logic         m_gie, m_isv, m_int;
  logic [4:0]   m_id;

  task automatic m_reset();
    m_pend = '0; m_prev = '0; m_mask = '0; m_mode = '0;
    m_gie = 0; m_isv = 0; m_int = 0; m_id = '0;
  endtask

  function automatic bit m_view(int i);
    return m_mode[i] ? m_pend[i] : m_prev[i];
  endfunction

  function automatic int m_cand();
    for (int i = 0; i < N; i++)
      if (m_view(i) && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(logic [1:0] a);
    logic [31:0] r;
    int c;
    r = '0;
    c = m_cand();
    case (a)
      2'd0: for (int i = 0; i < N; i++) r[i] = m_view(i);
      2'd1: r = 32'(m_mask);
      2'd2: r = 32'(m_mode);
      default: begin
        r[31] = m_isv;
        r[30] = (c >= 0);
        r[16] = m_gie;
        r[12:8] = (c >= 0) ? 5'(c) : 5'd0;
        r[4:0] = m_id;
      end
    endcase
    return r;
  endfunction

  task automatic m_step(logic [1:0] a, logic w, logic [31:0] d, logic k, logic e);
    int c;
    bit ackf, eoif, nint, rise, clr;
    c    = m_cand();
    ackf = k && m_int;
    eoif = e || (w && a == 2'd3 && d[1]);
    nint = m_gie && (c >= 0) && !m_isv && !k;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) begin
        rise = irq[i] && !m_prev[i];
        clr  = (w && a == 2'd0 && d[i]) || (ackf && c == i);
        if (rise) m_pend[i] = 1'b1;
        else if (clr) m_pend[i] = 1'b0;
      end else begin
        m_pend[i] = 1'b0;
      end
    end
    if (ackf) begin
      m_isv = 1'b1;
      m_id  = (c >= 0) ? 5'(c) : 5'd0;
    end else if (eoif) begin
      m_isv = 1'b0;
    end
    if (w) begin
      case (a)
        2'd1: m_mask = d[N-1:0];
        2'd2: m_mode = d[N-1:0];
        2'd3: m_gie  = d[0];
        default: ;
      endcase
    end
    m_prev = irq;
    m_int  = nint;
  endtask

  // One bus cycle: queue the expected view, let the monitor compare, advance model.
  task automatic drive(logic [1:0] a, logic w, logic [31:0] d, logic k, logic e);
    bus.add_i = a; bus.we_i = w; bus.dat_i = d; ack = k; eoi = e;
    sb.push_back('{m_read(a), m_int, m_id, tagc});
    tagc++;
    rd_stb = 1'b1;
    @(negedge clk);
    m_step(a, w, d, k, e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rd_stb) begin
      exp_t x;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: no expected entry queued");
      end else begin
        x = sb.pop_front();
        if (bus.dat_o !== x.dat || int_o !== x.io || int_id !== x.id) begin
          n_fail++;
          $display("FAIL rd#%0d add=%0d: got dat=%h int=%b id=%0d, need dat=%h int=%b id=%0d",
                   x.tag, bus.add_i, bus.dat_o, int_o, int_id, x.dat, x.io, x.id);
        end
      end
    end
  end

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, need %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rd_stb = 1'b0;
    rst = 1'b1; irq = '0; ack = 0; eoi = 0;
    bus.we_i = 0; bus.dat_i = '0; bus.add_i = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_int_o", 32'(int_o), 0);
    check("rst_int_id", 32'(int_id), 0);
    check("rst_pend", bus.dat_o, 0);
    bus.add_i = 2'd3; #1;
    check("rst_vec", bus.dat_o, 0);
    rst = 1'b0;
    m_reset();
  endtask

  task automatic cfg(logic [N-1:0] mask, logic [N-1:0] mode, logic gie);
    drive(2'd1, 1, 32'(mask), 0, 0);
    drive(2'd2, 1, 32'(mode), 0, 0);
    drive(2'd3, 1, {31'd0, gie}, 0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single held edge-mode source: one interrupt only
    do_reset();
    cfg(6'h01, 6'h01, 1);
    irq = 6'h01;
    repeat (3) begin drive(2'd0, 0, 0, 0, 0); drive(2'd3, 0, 0, 0, 0); end
    drive(2'd3, 0, 0, m_int, 0);
    drive(2'd3, 0, 0, 0, 1);
    repeat (4) drive(2'd0, 0, 0, 0, 0);

    // Two simultaneous edges: priority, ack, EOI, second ack
    do_reset();
    cfg(6'h0A, 6'h0A, 1);
    irq = 6'h0A;
    repeat (3) drive(2'd3, 0, 0, 0, 0);
    drive(2'd3, 0, 0, m_int, 0);
    drive(2'd0, 0, 0, 0, 0);
    drive(2'd3, 0, 0, 0, 1);
    repeat (2) drive(2'd3, 0, 0, 0, 0);
    drive(2'd3, 0, 0, m_int, 0);
    drive(2'd3, 0, 0, 0, 0);

    // Level-mode source ignores W1C and follows the line
    do_reset();
    cfg(6'h04, 6'h00, 1);
    irq = 6'h04;
    repeat (2) drive(2'd0, 0, 0, 0, 0);
    drive(2'd0, 1, 32'h04, 0, 0);
    drive(2'd0, 0, 0, 0, 0);
    irq = 6'h00;
    repeat (2) drive(2'd0, 0, 0, 0, 0);

    // Edge set wins over same-cycle W1C
    do_reset();
    cfg(6'h00, 6'h01, 0);
    drive(2'd0, 0, 0, 0, 0);
    irq = 6'h01;
    drive(2'd0, 1, 32'h01, 0, 0);
    drive(2'd0, 0, 0, 0, 0);
    drive(2'd0, 1, 32'h01, 0, 0);
    drive(2'd0, 0, 0, 0, 0);

    // Ack with int_o low ignored; EOI+ack together: ack wins
    drive(2'd3, 0, 0, 1, 0);
    drive(2'd3, 0, 0, 0, 0);
    irq = 6'h00;
    cfg(6'h20, 6'h20, 1);
    irq = 6'h20;
    repeat (3) drive(2'd3, 0, 0, 0, 0);
    drive(2'd3, 0, 0, m_int, 1);
    drive(2'd3, 0, 0, 0, 0);

    // Async reset mid-service with PEND full
    do_reset();
    cfg(6'h3F, 6'h3F, 1);
    irq = 6'h3F;
    repeat (2) drive(2'd3, 0, 0, 0, 0);
    drive(2'd3, 0, 0, m_int, 0);
    irq = 6'h3E;
    drive(2'd0, 0, 0, 0, 0);
    irq = 6'h3F;
    drive(2'd0, 0, 0, 0, 0);
    drive(2'd3, 0, 0, 0, 0);
    rd_stb = 1'b0;
    bus.add_i = 2'd0;
    #1 rst = 1'b1;
    #1;
    check("arst_int_o", 32'(int_o), 0);
    check("arst_pend", bus.dat_o, 0);
    bus.add_i = 2'd3; #1;
    check("arst_vec", bus.dat_o, 0);
    check("arst_int_id", 32'(int_id), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    repeat (3) drive(2'd0, 0, 0, 0, 0);

    // Random traffic
    do_reset();
    cfg(N'($urandom), N'($urandom) | 6'h01, 1);
    drive(2'd1, 1, 32'($urandom) | 32'h3, 0, 0);
    for (int c = 0; c < 600; c++) begin
      logic [1:0] a;
      logic w, k, e;
      logic [31:0] d;
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) irq[i] = ~irq[i];
      k = m_int ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
      e = m_isv ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
      a = 2'($urandom_range(3));
      w = 1'b0;
      d = $urandom;
      if ($urandom_range(7) == 0) begin
        w = 1'b1;
        if (a == 2'd2) a = 2'd0;
        if (a == 2'd3) d[0] = ($urandom_range(5) != 0);
      end
      drive(a, w, d, k, e);
    end

    rd_stb = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Programmable interrupt controller downstream of the bus timers.
- Consumes the IRQ outputs of up to N_SRC devices (timers, UART, etc.), latches them as pending, masks and prioritises them, and presents a single registered interrupt request plus source ID to the CPU's CP0.
- Bus slave on the same bridge as the timers, with the same 2-bit word address / we / data protocol.
- Needed because timer IRQ is a sticky level that stays high; edge mode turns each rising edge into exactly one interrupt.

Parameters:
- N_SRC, 6, number of interrupt sources (1..32); bit i of every source-indexed register maps to irq_i[i].

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- add_i  in  2  word address: 0=PEND, 1=MASK, 2=MODE, 3=CTRL/VEC.
- we_i  in  1  write enable; write takes effect at the clock edge.
- dat_i  in  32  write data.
- dat_o  out  32  read data; combinational from add_i and registers.
- irq_i  in  N_SRC  device interrupt lines, synchronous to clk_i.
- int_ack_i  in  1  one-cycle pulse from CP0 on exception entry.
- eoi_i  in  1  one-cycle pulse from CP0 on eret.
- int_o  out  1  registered interrupt request to CP0.
- int_id_o  out  5  ID of the in-service source; valid while the VEC.ISV bit is 1.

Behaviour:
- Reset (async): PEND, MASK, MODE, irq_q, CTRL.GIE, isv and isv_id are all cleared. int_o=0, int_id_o=0. Reset mid-service drops the in-service state with no EOI required.
- irq_q: irq_i registered every cycle. Because irq_q resets to 0, a source already high at reset release gives one edge.
- Edge mode (MODE[i]=1):
  - PEND[i] sets at the edge where irq_i[i]=1 and irq_q[i]=0.
  - It clears on a write of 1 to PEND[i] (W1C), or on int_ack for source i.
  - If set and clear happen in the same cycle, set wins.
- Level mode (MODE[i]=0): PEND[i] = irq_q[i]. W1C writes and ack do not affect it; the source must be cleared at the device.
- Candidate: lowest index i with PEND[i] & MASK[i]. cand_v = 1 if any such i exists.
- int_o next value: CTRL.GIE & cand_v & !isv & !int_ack_i.
  - Latency: irq_i rises before edge k; PEND set at k; int_o high after edge k+1.
- int_ack_i with int_o=1 (one edge):
  - isv <= 1, isv_id <= cand_id.
  - Edge-mode PEND bit for that source cleared.
  - int_o <= 0.
- int_ack_i with int_o=0: ignored, no state change.
- EOI: eoi_i=1, or a write to address 3 with dat_i[1]=1, clears isv at that edge. A new int_o may assert at the following edge.
  - EOI with isv=0: no effect.
  - EOI and int_ack in the same cycle: ack wins. isv stays 1 with the new ID.
- No nesting: while isv=1, int_o stays 0 even for higher-priority sources. Their PEND bits still accumulate.
- Register map:
  - PEND: read gives PEND. Write is W1C, edge-mode bits only.
  - MASK: read/write.
  - MODE: read/write. Changing a bit from edge to level makes that PEND bit follow irq_q from the next edge.
  - Address 3 write: CTRL.GIE=dat_i[0]; dat_i[1] is EOI (self-clearing, never stored).
  - Address 3 read: [31]=isv, [30]=cand_v, [12:8]=cand_id, [4:0]=isv_id, [0] of a separate byte not used. GIE reads at [16].
- Bits at or above N_SRC: read 0, writes ignored. All other unused bits read 0.
- int_id_o = isv_id.

Decomposition:
- Shared package holds:
  - Address constants: A_PEND=0, A_MASK=1, A_MODE=2, A_CTRL=3.
  - VEC/CTRL bit positions: ISV=31, CANDV=30, GIE_RD=16, GIE_WR=0, EOI_WR=1.
  - ID width constant IDW=5.
- One sub-module: irq_prio_enc. Purely combinational: N_SRC request vector in, lowest-index ID and valid out.

Test Plan:
- Reset, then MASK=0x01, MODE=0x01, GIE=1. Pulse irq_i[0] high and hold it -> PEND=0x01 one edge later, int_o=1 the edge after, and only one interrupt despite the held level.
- irq_i[3] and irq_i[1] rise together, both unmasked edge mode -> int_o=1 with cand_id=1. After ack: int_id_o=1, PEND=0x08, int_o=0. After eoi: int_o=1 again and ack gives ID 3.
- Level mode source 2 held high. Write PEND=0x04 -> PEND bit stays 1. Drop irq_i[2] -> PEND[2]=0 one edge later.
- Edge on irq_i[0] in the same cycle as a W1C of PEND bit 0 -> PEND[0]=1 (set wins).
- int_ack_i pulsed with int_o=0 -> isv stays 0 and PEND is unchanged. EOI and ack in the same cycle with int_o=1 -> isv=1 with the new ID.
- Assert rst_i asynchronously while isv=1 and PEND=0x3F -> int_o, PEND and VEC read 0 immediately, with no clock edge needed.
